// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The optional PROG_LOADER_CHECKSUM_EN build uses csum_add().
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;

  localparam logic [NIB_W-1:0] OPC_STOP  = 4'b0011;
  localparam logic [11:0]      HALT_WORD = {OPC_STOP, 8'h00};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] a,
                                                  input logic [BYTE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: one synchronous write port, one asynchronous read port, no reset.
module prog_ram #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  logic [INST_W-1:0] r_mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader with read-mask mux in front of the program RAM.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] progaddr,
  output logic [INST_W-1:0] progdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_loaded
);

  state_e              r_state;
  logic                r_busy;
  logic                r_err;
  logic [ADDR_W-1:0]   r_words;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [BYTE_W-1:0]   r_lo;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]   r_csum;
`endif

  logic                w_xfer;
  logic                w_hi_ok;
  logic                w_last;
  logic                w_we;
  logic [ADDR_W-1:0]   w_len_in;
  logic [INST_W-1:0]   w_wdata;
  logic [INST_W-1:0]   w_rdata;
  logic                w_done;

  assign w_xfer   = in_valid & r_busy;
  assign w_hi_ok  = (in_data[7:4] == 4'h0);
  assign w_last   = (r_wr_addr == (r_len - ADDR_W'(1)));
  assign w_len_in = ADDR_W'(in_data);
  assign w_we     = (r_state == ST_HI) & w_xfer & w_hi_ok;
  assign w_wdata  = {in_data[3:0], r_lo};

  prog_ram #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (w_wdata),
    .i_raddr (progaddr),
    .o_rdata (w_rdata)
  );

  // Loader FSM, counters and checksum accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= '0;
      r_len     <= '0;
      r_wr_addr <= '0;
      r_lo      <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_state <= ST_LEN;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_words <= '0;
          end
        end
        ST_LEN: begin
          if (w_xfer) begin
            r_len     <= w_len_in;
            r_wr_addr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum    <= in_data;
`endif
            if (w_len_in == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_words <= '0;
`endif
            end else begin
              r_state <= ST_LO;
            end
          end
        end
        ST_LO: begin
          if (w_xfer) begin
            r_lo    <= in_data;
            r_state <= ST_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum  <= csum_add(r_csum, in_data);
`endif
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            if (!w_hi_ok) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
              r_csum    <= csum_add(r_csum, in_data);
`endif
              if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                r_state <= ST_CSUM;
`else
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_words <= r_len;
`endif
              end else begin
                r_state <= ST_LO;
              end
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            if (csum_add(r_csum, in_data) == 8'h00) begin
              r_words <= r_len;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Completion strobe coincides with the final byte transfer
  always_comb begin
    w_done = 1'b0;
    case (r_state)
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: w_done = w_xfer & (csum_add(r_csum, in_data) == 8'h00);
`else
      ST_LEN:  w_done = w_xfer & (w_len_in == '0);
      ST_HI:   w_done = w_xfer & w_hi_ok & w_last;
`endif
      default: w_done = 1'b0;
    endcase
  end

  assign in_ready     = r_busy;
  assign busy         = r_busy;
  assign err          = r_err;
  assign cpu_hold     = r_busy | r_err;
  assign words_loaded = r_words;
  assign done         = w_done;
  assign progdata     = ((progaddr < r_words) && !r_busy) ? w_rdata : HALT_WORD;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default and checksum builds).
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] progaddr;
  logic [11:0] progdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] words_loaded;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  logic       last_done;
  logic       early_done;
  logic [7:0] q_bytes[$];

  prog_loader dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .progaddr     (progaddr),
    .progdata     (progdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [11:0] exp);
    progaddr = a;
    #1;
    chk(tag, {20'h0, progdata}, {20'h0, exp});
  endtask

  // Called just after a posedge; returns just after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    last_done = done;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic run_load(input bit gaps, input bit poke);
    early_done = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    foreach (q_bytes[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      if (poke && i == 3) load_start = 1'b1;
      send_byte(q_bytes[i]);
      load_start = 1'b0;
      if (i != q_bytes.size() - 1) early_done = early_done | last_done;
    end
  endtask

  initial begin
    int d0;
    reset = 1'b0; load_start = 1'b0; in_data = 8'h00; in_valid = 1'b0; progaddr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // 1. reset state
    rd("rst_rd0", 8'h00, 12'h300);
    rd("rst_rd255", 8'hFF, 12'h300);
    chk("rst_hold", {31'h0, cpu_hold}, 32'd0);
    chk("rst_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_words", {24'h0, words_loaded}, 32'd0);
    reset = 1'b1;

    // 2. basic two-word load
    q_bytes = '{8'h02, 8'h84, 8'h08, 8'h85, 8'h09};
`ifdef PROG_LOADER_CHECKSUM_EN
    q_bytes.push_back(8'hE4);
`endif
    d0 = done_cnt;
    run_load(1'b0, 1'b0);
    chk("ld2_done_cnt", done_cnt - d0, 32'd1);
    chk("ld2_done_last", {31'h0, last_done}, 32'd1);
    chk("ld2_done_early", {31'h0, early_done}, 32'd0);
    chk("ld2_words", {24'h0, words_loaded}, 32'd2);
    chk("ld2_hold", {31'h0, cpu_hold}, 32'd0);
    rd("ld2_rd0", 8'h00, 12'h884);
    rd("ld2_rd1", 8'h01, 12'h985);
    rd("ld2_rd2", 8'h02, 12'h300);

    // 3. bad HI nibble, then recovery with a smaller program
    q_bytes = '{8'h02, 8'h84, 8'h18};
    d0 = done_cnt;
    run_load(1'b0, 1'b0);
    chk("err_flag", {31'h0, err}, 32'd1);
    chk("err_hold", {31'h0, cpu_hold}, 32'd1);
    chk("err_words", {24'h0, words_loaded}, 32'd0);
    chk("err_busy", {31'h0, busy}, 32'd0);
    chk("err_done_cnt", done_cnt - d0, 32'd0);
    rd("err_rd0", 8'h00, 12'h300);
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("restart_err", {31'h0, err}, 32'd0);
    chk("restart_busy", {31'h0, busy}, 32'd1);
    rd("busy_mask", 8'h00, 12'h300);
    q_bytes = '{8'h01, 8'h34, 8'h0A};
`ifdef PROG_LOADER_CHECKSUM_EN
    q_bytes.push_back(8'hC1);
`endif
    foreach (q_bytes[i]) send_byte(q_bytes[i]);
    chk("rec_words", {24'h0, words_loaded}, 32'd1);
    chk("rec_done", {31'h0, last_done}, 32'd1);
    chk("rec_hold", {31'h0, cpu_hold}, 32'd0);
    rd("rec_rd0", 8'h00, 12'hA34);
    rd("rec_stale1", 8'h01, 12'h300);

    // 4. reset in the middle of a load
    q_bytes = '{8'h03, 8'h11, 8'h02};
    run_load(1'b0, 1'b0);
    chk("mid_busy_pre", {31'h0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", {31'h0, busy}, 32'd0);
    chk("mid_ready", {31'h0, in_ready}, 32'd0);
    chk("mid_hold", {31'h0, cpu_hold}, 32'd0);
    chk("mid_err", {31'h0, err}, 32'd0);
    chk("mid_words", {24'h0, words_loaded}, 32'd0);
    rd("mid_rd0", 8'h00, 12'h300);
    rd("mid_rd1", 8'h01, 12'h300);
    @(posedge clk); #1;
    reset = 1'b1;

    // 5. random gaps and a load_start pulse while busy
    q_bytes = '{8'h03, 8'h21, 8'h01, 8'h22, 8'h02, 8'h23, 8'h03};
`ifdef PROG_LOADER_CHECKSUM_EN
    q_bytes.push_back(8'h91);
`endif
    d0 = done_cnt;
    run_load(1'b1, 1'b1);
    chk("gap_words", {24'h0, words_loaded}, 32'd3);
    chk("gap_done_cnt", done_cnt - d0, 32'd1);
    rd("gap_rd0", 8'h00, 12'h121);
    rd("gap_rd1", 8'h01, 12'h222);
    rd("gap_rd2", 8'h02, 12'h323);
    rd("gap_rd3", 8'h03, 12'h300);

`ifdef PROG_LOADER_CHECKSUM_EN
    // 6. bad checksum
    q_bytes = '{8'h02, 8'h84, 8'h08, 8'h85, 8'h09, 8'hE5};
    d0 = done_cnt;
    run_load(1'b0, 1'b0);
    chk("cs_err", {31'h0, err}, 32'd1);
    chk("cs_done_cnt", done_cnt - d0, 32'd0);
    chk("cs_words", {24'h0, words_loaded}, 32'd0);
    q_bytes = '{8'h00, 8'h00};
`else
    q_bytes = '{8'h00};
`endif
    // empty program
    d0 = done_cnt;
    run_load(1'b0, 1'b0);
    chk("n0_done_cnt", done_cnt - d0, 32'd1);
    chk("n0_words", {24'h0, words_loaded}, 32'd0);
    chk("n0_busy", {31'h0, busy}, 32'd0);
    chk("n0_err", {31'h0, err}, 32'd0);
    rd("n0_rd0", 8'h00, 12'h300);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
